// File: rtl/uart_device_pkg.sv
// Shared UART / memory-bus definitions: state encodings, frame geometry, bus helpers.
package uart_device_pkg;

  localparam int unsigned MEM_DATA_W     = 16;
  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_IDX_W     = 3;
  localparam int unsigned BIT_CNT_W      = 16;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [MEM_DATA_W-1:0] bus_word(input logic [UART_DATA_BITS-1:0] b);
    return {{(MEM_DATA_W-UART_DATA_BITS){1'b0}}, b};
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: load starts a full or half period, then ticks every CLKS_PER_BIT cycles.
module uart_bit_timer
  import uart_device_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic load_i,
  input  logic half_i,
  output logic tick_o
);

  localparam logic [BIT_CNT_W-1:0] FULL = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] HALF = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;

  // Tick is independent of load so the FSMs can use it without a combinational loop.
  assign tick_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = half_i ? HALF : FULL;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? FULL : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_device.sv
// UART with a strobe-driven 16-bit shared bus: one holding register for TX, one receive buffer for RX.
module uart_device
  import uart_device_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [MEM_DATA_W-1:0] data,
  input  logic                  rdn,
  input  logic                  wrn,
  output logic                  data_ready,
  output logic                  tbre,
  output logic                  tsre,
  output logic                  txd,
  input  logic                  rxd,
  output logic                  overrun,
  output logic                  framing_err
);

  logic rdn_q, wrn_q, wr_rise, rd_rise;
  logic unused_bus_hi;

  tx_state_t                 tx_state_q, tx_state_d;
  logic [UART_DATA_BITS-1:0] thr_q, thr_d, tsr_q, tsr_d;
  logic [UART_IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic                      tbre_q, tbre_d, tsre_q, tsre_d, txd_q, txd_d;
  logic                      tx_load, tx_tick;

  rx_state_t                 rx_state_q, rx_state_d;
  logic [UART_DATA_BITS-1:0] rx_sh_q, rx_sh_d, rbr_q, rbr_d, pend_byte_q, pend_byte_d;
  logic [UART_IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic                      rx_s1_q, rx_s2_q, rx_prev_q;
  logic                      pend_q, pend_d, dr_q, dr_d, ov_q, ov_d, fe_q, fe_d;
  logic                      rx_load, rx_tick, rx_done, rbr_load, lost;

  assign wr_rise       = wrn & ~wrn_q;
  assign rd_rise       = rdn & ~rdn_q;
  assign unused_bus_hi = ^data[MEM_DATA_W-1:UART_DATA_BITS];

  assign data = (!rdn && !rst) ? bus_word(rbr_q) : {MEM_DATA_W{1'bz}};

  assign data_ready  = dr_q;
  assign overrun     = ov_q;
  assign framing_err = fe_q;
  assign tbre        = tbre_q;
  assign tsre        = tsre_q;
  assign txd         = txd_q;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk_i (clk), .rst_i (rst), .en_i (tx_state_q != TX_IDLE),
    .load_i(tx_load), .half_i(1'b0), .tick_o(tx_tick)
  );

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk_i (clk), .rst_i (rst), .en_i (rx_state_q != RX_IDLE),
    .load_i(rx_load), .half_i(1'b1), .tick_o(rx_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    thr_d      = thr_q;
    tsr_d      = tsr_q;
    tx_idx_d   = tx_idx_q;
    tbre_d     = tbre_q;
    tsre_d     = tsre_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (!tbre_q) begin
        tsr_d      = thr_q;
        tbre_d     = 1'b1;
        tsre_d     = 1'b0;
        tx_load    = 1'b1;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_tick) begin
        tx_idx_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_tick) begin
        tx_idx_d = tx_idx_q + 1'b1;
        if (tx_idx_q == UART_IDX_W'(UART_DATA_BITS - 1)) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_tick) begin
        // Timer reloads itself on the tick, so a queued byte starts with no idle bit.
        if (!tbre_q) begin
          tsr_d      = thr_q;
          tbre_d     = 1'b1;
          tx_state_d = TX_START;
        end else begin
          tsre_d     = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (wr_rise) begin
      thr_d  = data[UART_DATA_BITS-1:0];
      tbre_d = 1'b0;
    end
    case (tx_state_q)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tsr_q[tx_idx_q];
      default:  txd_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_sh_d    = rx_sh_q;
    rx_idx_d   = rx_idx_q;
    rx_load    = 1'b0;
    rx_done    = 1'b0;
    fe_d       = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_load    = 1'b1;
        rx_state_d = RX_START;
      end
      RX_START: if (rx_tick) begin
        rx_idx_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_tick) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[UART_DATA_BITS-1:1]};
        rx_idx_d = rx_idx_q + 1'b1;
        if (rx_idx_q == UART_IDX_W'(UART_DATA_BITS - 1)) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        rx_done    = rx_s2_q;
        fe_d       = !rx_s2_q;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // RBR must not change under an active read; park the byte until rdn rises.
    rbr_d       = rbr_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    rbr_load    = 1'b0;
    lost        = 1'b0;
    if (pend_q && rdn) begin
      rbr_d    = pend_byte_q;
      pend_d   = 1'b0;
      rbr_load = 1'b1;
    end
    if (rx_done) begin
      if (!rdn) begin
        pend_d      = 1'b1;
        pend_byte_d = rx_sh_q;
      end else begin
        lost     = rbr_load;
        rbr_d    = rx_sh_q;
        rbr_load = 1'b1;
      end
    end

    dr_d = dr_q;
    ov_d = ov_q;
    if (rd_rise) begin
      dr_d = 1'b0;
      ov_d = 1'b0;
    end
    if (rbr_load) begin
      if ((dr_q && !rd_rise) || lost) ov_d = 1'b1;
      dr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdn_q       <= 1'b1;
      wrn_q       <= 1'b1;
      tx_state_q  <= TX_IDLE;
      thr_q       <= '0;
      tsr_q       <= '0;
      tx_idx_q    <= '0;
      tbre_q      <= 1'b1;
      tsre_q      <= 1'b1;
      txd_q       <= 1'b1;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_sh_q     <= '0;
      rx_idx_q    <= '0;
      rbr_q       <= '0;
      pend_q      <= 1'b0;
      pend_byte_q <= '0;
      dr_q        <= 1'b0;
      ov_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      rdn_q       <= rdn;
      wrn_q       <= wrn;
      tx_state_q  <= tx_state_d;
      thr_q       <= thr_d;
      tsr_q       <= tsr_d;
      tx_idx_q    <= tx_idx_d;
      tbre_q      <= tbre_d;
      tsre_q      <= tsre_d;
      txd_q       <= txd_d;
      rx_s1_q     <= rxd;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_sh_q     <= rx_sh_d;
      rx_idx_q    <= rx_idx_d;
      rbr_q       <= rbr_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      dr_q        <= dr_d;
      ov_q        <= ov_d;
      fe_q        <= fe_d;
    end
  end

endmodule

// File: tb/tb_uart_device.sv
// Directed bench for uart_device at 16 clocks per bit; inputs change and outputs are sampled on negedge.
module tb_uart_device;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdn = 1'b1;
  logic        wrn = 1'b1;
  logic        rxd = 1'b1;
  logic        drv_en = 1'b0;
  logic [15:0] drv_val = 16'h0000;
  wire  [15:0] data;
  logic        data_ready, tbre, tsre, txd, overrun, framing_err;
  int          checks = 0;
  int          failures = 0;
  int          fe_seen = 0;

  assign data = drv_en ? drv_val : 16'hzzzz;

  always #5 clk = ~clk;

  uart_device #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst(rst), .data(data), .rdn(rdn), .wrn(wrn),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .txd(txd), .rxd(rxd),
    .overrun(overrun), .framing_err(framing_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {15'd0, obs}, {15'd0, exp});
  endtask

  // One frame (or two back-to-back frames) written through the bus and checked bit by bit at mid-bit.
  task automatic run_tx(input string tag, input logic [7:0] b0, input logic [7:0] b1, input bit two);
    logic [19:0] bits;
    int nb;
    bits = {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
    nb = two ? 20 : 10;
    drv_val = {8'h00, b0}; drv_en = 1'b1; wrn = 1'b0;
    @(negedge clk); wrn = 1'b1;
    @(negedge clk); drv_en = 1'b0;
    chk1({tag, "_tbre_lo"}, tbre, 1'b0);
    for (int c = 1; c <= nb * 16 + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk1({tag, "_tbre_hi"}, tbre, 1'b1);
        chk1({tag, "_tsre_lo"}, tsre, 1'b0);
      end
      if (c >= 10 && (c - 10) % 16 == 0 && (c - 10) / 16 < nb)
        chk1($sformatf("%s_bit%0d", tag, (c - 10) / 16), txd, bits[(c - 10) / 16]);
      if (c == nb * 16)     chk1({tag, "_tsre_end"}, tsre, 1'b0);
      if (c == nb * 16 + 1) chk1({tag, "_tsre_idle"}, tsre, 1'b1);
      if (two && c == 5)    chk1({tag, "_tbre2_lo"}, tbre, 1'b0);
      if (two && c == 160)  chk1({tag, "_tbre2_held"}, tbre, 1'b0);
      if (two && c == 161)  chk1({tag, "_tbre2_hi"}, tbre, 1'b1);
      if (two && c == 3) begin drv_val = {8'h00, b1}; drv_en = 1'b1; wrn = 1'b0; end
      if (two && c == 4) wrn = 1'b1;
      if (two && c == 5) drv_en = 1'b0;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_b);
    logic [9:0] f;
    f = {stop_b, b, 1'b0};
    fe_seen = 0;
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (framing_err) fe_seen++;
      end
    end
    rxd = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] exp);
    rdn = 1'b0;
    @(negedge clk); chk({tag, "_data0"}, data, exp);
    @(negedge clk); chk({tag, "_data1"}, data, exp);
    rdn = 1'b1;
    @(negedge clk);
    chk1({tag, "_dr_clr"}, data_ready, 1'b0);
    chk1({tag, "_ov_clr"}, overrun, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk1("rst_txd", txd, 1'b1);
    chk1("rst_tbre", tbre, 1'b1);
    chk1("rst_tsre", tsre, 1'b1);
    chk1("rst_dr", data_ready, 1'b0);
    chk1("rst_ov", overrun, 1'b0);
    chk1("rst_fe", framing_err, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    run_tx("tx55", 8'h55, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    run_tx("txb2b", 8'hA3, 8'h0F, 1'b1);
    repeat (5) @(negedge clk);

    drv_val = 16'h00F0; drv_en = 1'b1; wrn = 1'b0;
    @(negedge clk); wrn = 1'b1;
    @(negedge clk); drv_en = 1'b0;
    repeat (60) @(negedge clk);
    chk1("mid_tsre", tsre, 1'b0);
    chk1("mid_txd", txd, 1'b0);
    rst = 1'b1;
    #1;
    chk1("arst_txd", txd, 1'b1);
    chk1("arst_tbre", tbre, 1'b1);
    chk1("arst_tsre", tsre, 1'b1);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    run_tx("tx81", 8'h81, 8'h00, 1'b0);
    repeat (5) @(negedge clk);

    send_rx(8'hC4, 1'b1);
    chk("c4_fe", 16'(fe_seen), 16'd0);
    chk1("c4_dr", data_ready, 1'b1);
    chk1("c4_ov", overrun, 1'b0);
    rd_chk("c4", 16'h00C4);
    repeat (4) @(negedge clk);

    send_rx(8'h11, 1'b1);
    chk1("r11_dr", data_ready, 1'b1);
    chk1("r11_ov", overrun, 1'b0);
    send_rx(8'h22, 1'b1);
    chk1("r22_ov", overrun, 1'b1);
    chk1("r22_dr", data_ready, 1'b1);
    rd_chk("r22", 16'h0022);
    repeat (4) @(negedge clk);

    send_rx(8'h5A, 1'b0);
    chk("ferr_pulse", 16'(fe_seen), 16'd1);
    chk1("ferr_dr", data_ready, 1'b0);
    rdn = 1'b0;
    @(negedge clk); chk("ferr_rbr", data, 16'h0022);
    rdn = 1'b1;
    repeat (4) @(negedge clk);

    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    fe_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (framing_err) fe_seen++;
    end
    chk1("glitch_dr", data_ready, 1'b0);
    chk("glitch_fe", 16'(fe_seen), 16'd0);

    fork
      send_rx(8'h99, 1'b1);
      begin
        repeat (150) @(negedge clk);
        rdn = 1'b0;
        repeat (10) @(negedge clk);
        chk1("defer_hold_dr", data_ready, 1'b0);
        chk("defer_old_rbr", data, 16'h0022);
        rdn = 1'b1;
      end
    join
    @(negedge clk);
    chk1("defer_load_dr", data_ready, 1'b1);
    chk1("defer_load_ov", overrun, 1'b0);
    rd_chk("r99", 16'h0099);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
